// File: rtl/mp_addsub_pkg.sv
// Shared types for the word-serial multi-precision adder/subtractor.
package mp_addsub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } mp_state_t;

endpackage : mp_addsub_pkg

// File: rtl/mp_word_add.sv
// Combinational W-bit adder with carry-in and carry-out.
module mp_word_add #(
   parameter int unsigned W = 8
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W-1:0] sum,
   output logic         cout
);

   logic [W:0] full;

   // Widen by one bit so the top bit of the result is the carry out.
   always_comb begin
      full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
      sum  = full[W-1:0];
      cout = full[W];
   end

endmodule : mp_word_add

// File: rtl/mp_addsub_seq.sv
// Word-serial N*W-bit adder/subtractor: one W-bit word per RUN cycle,
// least significant word first, with valid/ready handshakes on both sides.
// Optional feature: define MP_ADDSUB_OVF_EN to add the signed-overflow output ovf.
module mp_addsub_seq
   import mp_addsub_pkg::*;
#(
   parameter int unsigned W = 8,
   parameter int unsigned N = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic           op_sub,
   input  logic [N*W-1:0] a,
   input  logic [N*W-1:0] b,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [N*W-1:0] result,
   output logic           carry_out,
`ifdef MP_ADDSUB_OVF_EN
   output logic           ovf,
`endif
   output logic           busy
);

   localparam int unsigned KW     = (N > 1) ? $clog2(N) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(N - 1);

   mp_state_t      state_q, state_d;
   logic [N*W-1:0] a_q, a_d;
   logic [N*W-1:0] b_q, b_d;
   logic           sub_q, sub_d;
   logic [N*W-1:0] res_q, res_d;
   logic           carry_q, carry_d;
   logic [KW-1:0]  k_q, k_d;
`ifdef MP_ADDSUB_OVF_EN
   logic           ovf_q, ovf_d;
`endif

   logic [W-1:0]   word_a, word_b, word_sum;
   logic           word_cout;

   // Select word k of the captured operands; subtraction adds the inverted
   // subtrahend with the carry register preset to 1.
   always_comb begin
      word_a = a_q[k_q*W +: W];
      word_b = b_q[k_q*W +: W] ^ {W{sub_q}};
   end

   mp_word_add #(
      .W (W)
   ) u_word_add (
      .a    (word_a),
      .b    (word_b),
      .cin  (carry_q),
      .sum  (word_sum),
      .cout (word_cout)
   );

   // Next-state, datapath update and handshake outputs.
   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      sub_d     = sub_q;
      res_d     = res_q;
      carry_d   = carry_q;
      k_d       = k_q;
`ifdef MP_ADDSUB_OVF_EN
      ovf_d     = ovf_q;
`endif
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      unique case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) begin
               a_d     = a;
               b_d     = b;
               sub_d   = op_sub;
               k_d     = '0;
               carry_d = op_sub;
               state_d = RUN;
            end
         end
         RUN: begin
            res_d[k_q*W +: W] = word_sum;
            carry_d           = word_cout;
            if (k_q == K_LAST) begin
`ifdef MP_ADDSUB_OVF_EN
               // Carry into the MSB is recovered as a ^ b ^ sum at that bit.
               ovf_d = word_a[W-1] ^ word_b[W-1] ^ word_sum[W-1] ^ word_cout;
`endif
               k_d     = '0;
               state_d = DONE;
            end else begin
               k_d = k_q + 1'b1;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset wins over any handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sub_q   <= 1'b0;
         res_q   <= '0;
         carry_q <= 1'b0;
         k_q     <= '0;
`ifdef MP_ADDSUB_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sub_q   <= sub_d;
         res_q   <= res_d;
         carry_q <= carry_d;
         k_q     <= k_d;
`ifdef MP_ADDSUB_OVF_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   assign result    = res_q;
   assign carry_out = carry_q;
`ifdef MP_ADDSUB_OVF_EN
   assign ovf       = ovf_q;
`endif

endmodule : mp_addsub_seq

// File: doc/mp_addsub_seq.md
MP_ADDSUB_SEQ -- requirements
Module: mp_addsub_seq

Interface
REQ-001 SHALL have parameter W, default 8, the adder word width in bits (W >= 1).
REQ-002 SHALL have parameter N, default 4, the operand width in words (N >= 1); operand width is N*W.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  a, b and op_sub are valid.
REQ-006 SHALL have port in_ready  output  1  the block accepts an operation this cycle.
REQ-007 SHALL have port op_sub  input  1  0 selects a+b, 1 selects a-b.
REQ-008 SHALL have ports a and b  input  N*W  the unsigned/two's-complement operands.
REQ-009 SHALL have port out_valid  output  1  result, carry_out and ovf are valid.
REQ-010 SHALL have port out_ready  input  1  the consumer takes the result this cycle.
REQ-011 SHALL have port result  output  N*W  the sum or difference modulo 2^(N*W).
REQ-012 SHALL have port carry_out  output  1  the final carry; for subtraction, 1 means no borrow.
REQ-013 SHALL have port busy  output  1  high in RUN and DONE.

Function
REQ-014 SHALL implement FSM states IDLE, RUN and DONE.
REQ-015 SHALL drive in_ready=1 only in IDLE; accept = in_valid && in_ready; on accept, capture a, b and op_sub, set word index k=0, set carry register = op_sub, and go to RUN.
REQ-016 SHALL ignore in_valid and operand changes outside IDLE; captured operands stay stable for the whole operation.
REQ-017 SHALL, in RUN cycle k, add word k of a, word k of b (inverted when op_sub=1) and the carry register on one W-bit adder, write the sum to result word k, and write the adder carry to the carry register.
REQ-018 SHALL go to DONE after RUN cycle k=N-1; an operation accepted at edge T enters DONE at edge T+N, so out_valid is high for the first time in cycle T+N.
REQ-019 SHALL hold out_valid=1, result and carry_out stable in DONE until out_valid && out_ready, then go to IDLE on that edge.
REQ-020 SHALL give one DONE cycle when out_ready is already high on entry; minimum throughput is one operation per N+2 cycles.
REQ-021 SHALL work correctly for N=1: one RUN cycle, no index wrap.
REQ-022 SHALL wrap word index k only as 0..N-1; k is never read outside RUN.

Reset
REQ-023 SHALL, while rst=1 on a rising edge, go to IDLE and clear result, carry_out, ovf, k and the carry register to 0; out_valid=0, busy=0, in_ready=1 from the next cycle.
REQ-024 SHALL discard an in-progress or pending operation when reset occurs in RUN or DONE, and produce no out_valid for it.
REQ-025 SHALL give reset priority over accept and handshake events in the same cycle.

Configuration
REQ-026 SHALL support macro MP_ADDSUB_OVF_EN: when defined, output port ovf (1 bit) exists and reports signed overflow, carry-into-MSB XOR carry-out-of-MSB, captured in the last RUN cycle and held in DONE.
REQ-027 SHALL, when MP_ADDSUB_OVF_EN is undefined, have no ovf port and no overflow logic; all other behaviour is identical.

Structure
REQ-028 SHALL place the FSM state enum typedef (IDLE, RUN, DONE) in shared package mp_addsub_pkg.
REQ-029 SHALL instantiate exactly one sub-module, mp_word_add: a combinational W-bit adder with carry-in and carry-out; all sequencing stays in mp_addsub_seq.

Verification (W=8, N=4)
REQ-030 SHALL check add: a=0x000000FF, b=0x00000001, op_sub=0 -> result=0x00000100, carry_out=0, out_valid exactly 4 cycles after accept.
REQ-031 SHALL check wrap: a=0xFFFFFFFF, b=0x00000001, add -> result=0x00000000, carry_out=1; with OVF_EN, ovf=0.
REQ-032 SHALL check borrow: a=0x00000000, b=0x00000001, op_sub=1 -> result=0xFFFFFFFF, carry_out=0; a=5, b=3, sub -> result=0x00000002, carry_out=1.
REQ-033 SHALL check overflow (OVF_EN): a=0x7FFFFFFF, b=0x00000001, add -> result=0x80000000, ovf=1.
REQ-034 SHALL check backpressure: out_ready=0 for 5 cycles in DONE -> result stable and in_ready=0 throughout; in_valid pulses are ignored; release -> IDLE next cycle.
REQ-035 SHALL check reset in RUN at k=2 -> IDLE, all outputs 0, no out_valid; a following 0x1+0x1 yields 0x00000002.
